// File: rtl/pipelined_addsub_pkg.sv
// Shared mode encodings and constant helpers for pipelined_addsub and its ripple slice.
package pipelined_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest operand the saturation pattern helpers can describe.
  localparam int SAT_MAX_W = 256;

  function automatic int chunk_width(input int width, input int stages);
    return (stages > 0) ? width / stages : width;
  endfunction

  // Signed maximum 0111..1 in the low `width` bits.
  function automatic logic [SAT_MAX_W-1:0] sat_pos(input int width);
    logic [SAT_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_MAX_W; i++) begin
      r[i] = (i < width - 1);
    end
    return r;
  endfunction

  // Signed minimum 1000..0 in the low `width` bits.
  function automatic logic [SAT_MAX_W-1:0] sat_neg(input int width);
    logic [SAT_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_MAX_W; i++) begin
      r[i] = (i == width - 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/pipelined_addsub_slice.sv
// addsub_slice: W-bit combinational ripple-carry slice, also exporting the carry into its MSB.
// Latency: zero (purely combinational).
// Backpressure: none; the enclosing pipeline stage decides when its result is captured.
module addsub_slice
  import pipelined_addsub_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         cmsb_o
);

  always_comb begin : p_ripple
    logic [W:0] c;
    c     = '0;
    c[0]  = cin_i;
    sum_o = '0;
    for (int i = 0; i < W; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = c[W];
    cmsb_o = c[W-1];
  end

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/sub, carry chain split into STAGES ripple chunks; PIPELINED_ADDSUB_SAT_EN saturates on overflow.
// Latency: STAGES cycles, throughput one beat per cycle.
// Backpressure: per-stage valid/ready; a stage loads when empty or when its successor drains, so bubbles collapse.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must be >= 2 and an exact multiple of STAGES");
  end

  // Operands travel with the partial sum so each stage sees its own unresolved chunk.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             c_msb;
  } beat_t;

  beat_t             stg_in [STAGES];
  beat_t             stg_d  [STAGES];
  beat_t             stg_q  [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_src;
  logic [STAGES-1:0] rdy;
  logic [CHUNK-1:0]  sl_sum [STAGES];
  logic [STAGES-1:0] sl_cout;
  logic [STAGES-1:0] sl_cmsb;

  always_comb begin
    stg_in[0]   = '0;
    stg_in[0].a = a;
    stg_in[0].b = (sub == OP_SUB) ? ~b : b;
    stg_in[0].c = (sub == OP_SUB) ? 1'b1 : cin;
    vld_src[0]  = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      stg_in[k]  = stg_q[k-1];
      vld_src[k] = vld_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_slice #(.W(CHUNK)) u_slice (
      .a_i    (stg_in[k].a[k*CHUNK +: CHUNK]),
      .b_i    (stg_in[k].b[k*CHUNK +: CHUNK]),
      .cin_i  (stg_in[k].c),
      .sum_o  (sl_sum[k]),
      .cout_o (sl_cout[k]),
      .cmsb_o (sl_cmsb[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stg_d[k]                      = stg_in[k];
      stg_d[k].s[k*CHUNK +: CHUNK]  = sl_sum[k];
      stg_d[k].c                    = sl_cout[k];
      stg_d[k].c_msb                = sl_cmsb[k];
    end
  end

  // Ready ripples back from the sink; accumulated in a local to keep the chain acyclic.
  always_comb begin : p_ready
    logic downstream;
    downstream = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      downstream = !vld_q[k] || downstream;
      rdy[k]     = downstream;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        stg_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld_q[k] <= vld_src[k];
          if (vld_src[k]) begin
            stg_q[k] <= stg_d[k];
          end
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_q[STAGES-1];
  assign cout      = stg_q[STAGES-1].c;
  assign ovf       = stg_q[STAGES-1].c ^ stg_q[STAGES-1].c_msb;

`ifdef PIPELINED_ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SAT_P = WIDTH'(sat_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_N = WIDTH'(sat_neg(WIDTH));

  // Overflow implies A and b_eff share a sign, so A's MSB gives the true result's sign.
  assign sum = !ovf ? stg_q[STAGES-1].s
                    : (stg_q[STAGES-1].a[WIDTH-1] ? SAT_N : SAT_P);
`else
  assign sum = stg_q[STAGES-1].s;
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench: 8-bit/2-stage directed vectors with stall and reset scenarios, then 32-bit/4-stage random traffic.
module tb_pipelined_addsub;

`ifdef PIPELINED_ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  exp_t q8[$];
  exp_t q32[$];
  exp_t e8, e32;
  vec_t vt[12];

  // 8-bit / 2-stage DUT
  logic       in_valid8, in_ready8, sub8, cin8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;

  pipelined_addsub #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sub(sub8), .cin(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  // 32-bit / 4-stage DUT
  logic        in_valid32, in_ready32, sub32, cin32, out_valid32, out_ready32, cout32, ovf32;
  logic [31:0] a32, b32, sum32;

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .sub(sub32), .cin(cin32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .sum(sum32), .cout(cout32), .ovf(ovf32)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
  endtask

  // Golden 32-bit reference built on native arithmetic.
  function automatic exp_t model32(input logic [31:0] av, input logic [31:0] bv,
                                   input logic sv, input logic cv);
    exp_t        e;
    logic [32:0] full;
    logic [31:0] beff;
    beff   = sv ? ~bv : bv;
    full   = {1'b0, av} + {1'b0, beff} + {32'b0, (sv ? 1'b1 : cv)};
    e.sum  = full[31:0];
    e.cout = full[32];
    e.ovf  = (av[31] == beff[31]) && (e.sum[31] != av[31]);
    if (SAT && e.ovf) e.sum = av[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    e.cyc  = 0;
    return e;
  endfunction

  task automatic send8(input vec_t v);
    exp_t e;
    bit   done;
    done = 1'b0;
    a8 = v.a; b8 = v.b; sub8 = v.sub; cin8 = v.cin; in_valid8 = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (in_ready8) begin
        e.sum = {24'h0, v.s}; e.cout = v.co; e.ovf = v.ov; e.cyc = cyc;
        q8.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    if (!done) fail_now("send8_accept");
  endtask

  task automatic send32(input logic [31:0] av, input logic [31:0] bv, input logic sv, input logic cv);
    exp_t e;
    bit   done;
    done = 1'b0;
    a32 = av; b32 = bv; sub32 = sv; cin32 = cv; in_valid32 = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready32) begin
        e = model32(av, bv, sv, cv);
        e.cyc = cyc;
        q32.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid32 = 1'b0;
    if (!done) fail_now("send32_accept");
  endtask

  task automatic drain8();
    for (int t = 0; t < 50 && q8.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    if (q8.size() != 0) fail_now("drain8");
  endtask

  task automatic drain32();
    for (int t = 0; t < 200 && q32.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    if (q32.size() != 0) fail_now("drain32");
  endtask

  // Monitors: pop on handshake, check stall stability and no-stall latency.
  int         last_stall8 = -1;
  bit         hold8 = 1'b0;
  logic [9:0] prev8;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold8 = 1'b0;
    end else begin
      if (!out_ready8) last_stall8 = cyc;
      if (hold8 && out_valid8) chk("hold8", 64'({cout8, ovf8, sum8}), 64'(prev8));
      if (out_valid8 && out_ready8) begin
        if (q8.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected8: got beat sum=%0h expected no beat (cycle %0d)", sum8, cyc);
        end else begin
          e8 = q8.pop_front();
          chk("out8", 64'({cout8, ovf8, sum8}), 64'({e8.cout, e8.ovf, e8.sum[7:0]}));
          if (last_stall8 <= e8.cyc) chk("lat8", 64'(cyc - e8.cyc), 64'd2);
        end
      end
      hold8 = out_valid8 && !out_ready8;
      prev8 = {cout8, ovf8, sum8};
    end
  end

  int          last_stall32 = -1;
  bit          hold32 = 1'b0;
  logic [33:0] prev32;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold32 = 1'b0;
    end else begin
      if (!out_ready32) last_stall32 = cyc;
      if (hold32 && out_valid32) chk("hold32", 64'({cout32, ovf32, sum32}), 64'(prev32));
      if (out_valid32 && out_ready32) begin
        if (q32.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected32: got beat sum=%0h expected no beat (cycle %0d)", sum32, cyc);
        end else begin
          e32 = q32.pop_front();
          chk("out32", 64'({cout32, ovf32, sum32}), 64'({e32.cout, e32.ovf, e32.sum}));
          if (last_stall32 <= e32.cyc) chk("lat32", 64'(cyc - e32.cyc), 64'd4);
        end
      end
      hold32 = out_valid32 && !out_ready32;
      prev32 = {cout32, ovf32, sum32};
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  bit rnd_done = 1'b0;

  initial begin
    // a, b, sub, cin, sum, cout, ovf -- computed by hand for 8 bits
    vt[0]  = '{8'h7F, 8'h01, 1'b0, 1'b0, (SAT ? 8'h7F : 8'h80), 1'b0, 1'b1};
    vt[1]  = '{8'h05, 8'h03, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0};
    vt[2]  = '{8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
    vt[3]  = '{8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vt[4]  = '{8'h80, 8'h01, 1'b1, 1'b0, (SAT ? 8'h80 : 8'h7F), 1'b1, 1'b1};
    vt[5]  = '{8'h3C, 8'h0F, 1'b0, 1'b1, 8'h4C, 1'b0, 1'b0};
    vt[6]  = '{8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vt[7]  = '{8'h80, 8'h80, 1'b0, 1'b0, (SAT ? 8'h80 : 8'h00), 1'b1, 1'b1};
    vt[8]  = '{8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[9]  = '{8'h7F, 8'h80, 1'b1, 1'b0, (SAT ? 8'h7F : 8'hFF), 1'b0, 1'b1};
    vt[10] = '{8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
    vt[11] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; cin8 = 1'b0; out_ready8 = 1'b1;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; sub32 = 1'b0; cin32 = 1'b0; out_ready32 = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid8", 64'(out_valid8), 64'd0);
    chk("rst_in_ready8", 64'(in_ready8), 64'd1);
    chk("rst_result8", 64'({cout8, ovf8, sum8}), 64'd0);
    chk("rst_out_valid32", 64'(out_valid32), 64'd0);
    chk("rst_in_ready32", 64'(in_ready32), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready8", 64'(in_ready8), 64'd1);

    // Isolated beats
    for (int i = 0; i < 4; i++) begin
      send8(vt[i]);
      drain8();
    end

    // Back-to-back stream with the sink stalled for four cycles
    fork
      begin
        for (int i = 0; i < 12; i++) send8(vt[i]);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready8 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("full_in_ready8", 64'(in_ready8), 64'd0);
        chk("full_out_valid8", 64'(out_valid8), 64'd1);
        @(posedge clk);
        #1 out_ready8 = 1'b1;
        @(negedge clk);
        chk("rise_in_ready8", 64'(in_ready8), 64'd1);
      end
    join
    drain8();

    // Reset with two beats in flight
    out_ready8 = 1'b0;
    send8(vt[4]);
    send8(vt[5]);
    @(negedge clk);
    chk("inflight_out_valid8", 64'(out_valid8), 64'd1);
    chk("inflight_in_ready8", 64'(in_ready8), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid8", 64'(out_valid8), 64'd0);
    chk("async_rst_result8", 64'({cout8, ovf8, sum8}), 64'd0);
    chk("async_rst_in_ready8", 64'(in_ready8), 64'd1);
    q8.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("no_stale_out_valid8", 64'(out_valid8), 64'd0);
    @(posedge clk); #1;
    send8(vt[6]);
    drain8();

    // 32-bit: corner cases then random traffic with a random sink
    send32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send32(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
    send32(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
    send32(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1);
    drain32();
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          send32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 7) == 0) begin
            @(posedge clk); #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready32 = 1'($urandom_range(0, 1));
        end
        out_ready32 = 1'b1;
      end
    join
    drain32();

    chk("q8_empty", 64'(q8.size()), 64'd0);
    chk("q32_empty", 64'(q32.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
